i2s_codec_target: RTL and testbench
===================================

Name: i2s_codec_target

Overview:
- Codec-side (target) end of the audio serial link.
- Accepts externally generated AUD_BCLK/AUD_DACLRCK/AUD_ADCLRCK, deserializes AUD_DACDAT into per-channel playback samples, and serializes capture samples onto AUD_ADCDAT.
- Serves as the on-chip loopback/codec model for the audio master and as a target for external masters.
- Format: left-justified, MSB first, LRCK high = left, WIDTH data bits per channel; bits beyond WIDTH ignored.

Parameters:
- WIDTH, 16, bits per channel sample.
- SYNC_STAGES, 2, synchronizer flops on each pin input. 0 is legal when BCLK/LRCK are generated from clk.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- AUD_BCLK  in  1  bit clock from master
- AUD_DACLRCK  in  1  playback frame clock (1 = left)
- AUD_DACDAT  in  1  playback serial data, sampled on BCLK rise
- AUD_ADCLRCK  in  1  capture frame clock (1 = left)
- AUD_ADCDAT  out  1  capture serial data, changes after BCLK rise
- dac_sample  out  WIDTH  last received playback word
- dac_valid  out  2  one-cycle pulse; [1] left, [0] right word on dac_sample
- adc_left  in  WIDTH  capture sample for left channel
- adc_right  in  WIDTH  capture sample for right channel
- adc_req  out  2  one-cycle pulse; [1]/[0] when adc_left/adc_right is latched
- frame_err  out  2  one-cycle pulse; [1]/[0] left/right slot ended with fewer than WIDTH bits

Behaviour:
- Reset: dac_sample=0, dac_valid=0, adc_req=0, frame_err=0, AUD_ADCDAT=0, bit counters=0, armed flags=0, edge-detect history loaded with the current synced pin levels (no edge reported on the first cycle after reset).
- Input conditioning:
  - All four pins pass through SYNC_STAGES flops plus one history flop.
  - Equal delay on every pin keeps data aligned with its clock edges.
  - Edge detection latency is SYNC_STAGES+1 clk.
- Timing constraints: BCLK high and low phases must each be ≥1 clk. BCLK period must be > SYNC_STAGES+2 clk.
- DAC receive path (framed by synced DACLRCK):
  - LRCK edge:
    - If armed and 0 ≤ cnt < WIDTH: pulse frame_err[old LRCK level].
    - Then cnt←0, shift←0, chan←new LRCK level, armed←1.
  - The first LRCK edge after reset never flags an error.
  - BCLK rise with cnt<WIDTH and armed: shift←{shift[WIDTH-2:0],dat}, cnt++.
  - On the rise that captures bit WIDTH:
    - dac_sample←completed word and dac_valid[chan]←1, both registered (visible next clk).
    - Total latency from pin edge to valid is SYNC_STAGES+2 clk.
  - Rises with cnt==WIDTH are ignored; cnt saturates.
  - LRCK edge and BCLK rise detected in the same cycle: the LRCK edge is processed first, and the rise captures the MSB of the new slot.
- ADC transmit path (framed by synced ADCLRCK):
  - AUD_ADCDAT = txshift[WIDTH-1] (registered).
  - Preload: when the current slot's bit counter reaches WIDTH, load txshift with the opposite channel's input (adc_right if current LRCK=1, else adc_left) and pulse adc_req for that channel. The MSB is then stable before the next LRCK edge.
  - LRCK edge:
    - txcnt←0, chan←new level.
    - If no preload occurred this slot (first slot after reset, or a short slot), load txshift from the new channel's input and pulse adc_req[new].
  - BCLK rise with txcnt<WIDTH: txcnt++. If txcnt+1<WIDTH, txshift←{txshift[WIDTH-2:0],0}, so the next bit appears after the master has sampled the current one.
  - After WIDTH bits and before preload completes, AUD_ADCDAT holds the last bit. Preload replaces it within 1 clk.
- Reset asserted mid-slot: all state clears. The next LRCK edge rearms without raising an error.
- DAC and ADC frame clocks are independent; identical pins must give identical framing.

Decomposition:
- Shared audio package:
  - Channel index constants CH_LEFT=1, CH_RIGHT=0.
  - Default WIDTH=16.
  - SYNC_STAGES default.
- Natural sub-module: i2s_pin_sync. Parameterized SYNC_STAGES-deep synchronizer plus history flop, outputs level/rise/fall. Instantiated once per pin (4x).

Test Plan:
- SYNC_STAGES=0, master-style timing (BCLK=clk/4, 64-clk slots), DACDAT left=16'hA5C3, right=16'h0F0F -> dac_valid[1] with dac_sample=16'hA5C3, then dac_valid[0] with 16'h0F0F. No frame_err.
- adc_left=16'h8001, adc_right=16'h7FFE held constant, bits sampled on BCLK rise -> left slot reads 16'h8001 and right slot reads 16'h7FFE. adc_req pulses once per slot, for the opposite channel at its preload.
- Short slot: LRCK toggles after 9 BCLK rises in a left slot -> frame_err[1] pulse, no dac_valid[1]. The next right slot still delivers its word.
- Extra bits: 24 BCLK rises per slot, first 16 = 16'h1234 -> dac_sample=16'h1234 and the trailing 8 bits are ignored. AUD_ADCDAT shows the next-channel MSB after bit 16.
- Reset asserted for 1 clk mid left slot, after 5 bits -> all outputs 0. The first following LRCK edge gives no frame_err, and the next full slot is received correctly.
- SYNC_STAGES=2 with BCLK period 8 clk, asynchronous phase offset -> same words as test 1, dac_valid latency = SYNC_STAGES+2 clk after the 16th BCLK rise.

Source files
------------

// File: rtl/i2s_codec_target_pkg.sv
// rtl/i2s_codec_target_pkg.sv - shared constants for the codec-side audio serial link
package i2s_codec_target_pkg;

  // Channel indices used for dac_valid, adc_req and frame_err bit positions
  localparam int CH_LEFT  = 1;
  localparam int CH_RIGHT = 0;

  localparam int DEFAULT_WIDTH       = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/i2s_pin_sync.sv
// rtl/i2s_pin_sync.sv - pin synchronizer with history flop and edge detect
module i2s_pin_sync
  import i2s_codec_target_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic synced;
  logic hist_q;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign synced = pin_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift the raw pin through the synchronizer chain
      always_ff @(posedge clk) begin
        sync_q[0] <= pin_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end

      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // History always tracks the synced level, so reset leaves no phantom edge
  always_ff @(posedge clk) begin
    hist_q <= synced;
  end

  assign level_o = synced;
  assign rise_o  = synced & ~hist_q;
  assign fall_o  = ~synced & hist_q;

endmodule

// File: rtl/i2s_codec_target.sv
// rtl/i2s_codec_target.sv - codec-side target: playback deserializer and capture serializer
module i2s_codec_target
  import i2s_codec_target_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             AUD_BCLK,
  input  logic             AUD_DACLRCK,
  input  logic             AUD_DACDAT,
  input  logic             AUD_ADCLRCK,
  output logic             AUD_ADCDAT,
  output logic [WIDTH-1:0] dac_sample,
  output logic [1:0]       dac_valid,
  input  logic [WIDTH-1:0] adc_left,
  input  logic [WIDTH-1:0] adc_right,
  output logic [1:0]       adc_req,
  output logic [1:0]       frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL    = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic bclk_lvl, bclk_rise, bclk_fall;
  logic dlrck_lvl, dlrck_rise, dlrck_fall;
  logic ddat_lvl, ddat_rise, ddat_fall;
  logic alrck_lvl, alrck_rise, alrck_fall;
  logic dlrck_edge, alrck_edge;
  logic unused_edges;

  i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(clk), .pin_i(AUD_BCLK), .level_o(bclk_lvl), .rise_o(bclk_rise), .fall_o(bclk_fall));
  i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dlrck (
    .clk(clk), .pin_i(AUD_DACLRCK), .level_o(dlrck_lvl), .rise_o(dlrck_rise), .fall_o(dlrck_fall));
  i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ddat (
    .clk(clk), .pin_i(AUD_DACDAT), .level_o(ddat_lvl), .rise_o(ddat_rise), .fall_o(ddat_fall));
  i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_alrck (
    .clk(clk), .pin_i(AUD_ADCLRCK), .level_o(alrck_lvl), .rise_o(alrck_rise), .fall_o(alrck_fall));

  assign dlrck_edge   = dlrck_rise | dlrck_fall;
  assign alrck_edge   = alrck_rise | alrck_fall;
  assign unused_edges = &{1'b0, bclk_lvl, bclk_fall, ddat_rise, ddat_fall};

  // Playback receive state
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
  logic             rx_chan_q, rx_chan_d;
  logic             rx_armed_q, rx_armed_d;
  logic             rx_done_q, rx_done_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [1:0]       valid_q, valid_d;
  logic [1:0]       ferr_q, ferr_d;

  // Frame edge first, then any coincident BCLK rise lands as bit 1 of the new slot
  always_comb begin
    rx_shift_d = rx_shift_q;
    rx_cnt_d   = rx_cnt_q;
    rx_chan_d  = rx_chan_q;
    rx_armed_d = rx_armed_q;
    rx_done_d  = 1'b0;
    sample_d   = sample_q;
    valid_d    = 2'b00;
    ferr_d     = 2'b00;
    if (rx_done_q) begin
      sample_d           = rx_shift_q;
      valid_d[rx_chan_q] = 1'b1;
    end
    if (dlrck_edge) begin
      if (rx_armed_q && (rx_cnt_q < FULL)) begin
        ferr_d[dlrck_lvl ? CH_RIGHT : CH_LEFT] = 1'b1;
      end
      rx_cnt_d   = '0;
      rx_shift_d = '0;
      rx_chan_d  = dlrck_lvl;
      rx_armed_d = 1'b1;
    end
    if (bclk_rise && rx_armed_d && (rx_cnt_d < FULL)) begin
      rx_shift_d = {rx_shift_d[WIDTH-2:0], ddat_lvl};
      rx_cnt_d   = rx_cnt_d + CNT_ONE;
      rx_done_d  = (rx_cnt_d == FULL);
    end
  end

  // Register playback state
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
      rx_chan_q  <= 1'b0;
      rx_armed_q <= 1'b0;
      rx_done_q  <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 2'b00;
      ferr_q     <= 2'b00;
    end else begin
      rx_shift_q <= rx_shift_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_chan_q  <= rx_chan_d;
      rx_armed_q <= rx_armed_d;
      rx_done_q  <= rx_done_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // Capture transmit state
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
  logic             tx_pre_q, tx_pre_d;
  logic [1:0]       req_q, req_d;

  // Preload the next channel once the slot is full, so its MSB is ready before the frame edge
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_pre_d   = tx_pre_q;
    req_d      = 2'b00;
    if (alrck_edge) begin
      tx_cnt_d = '0;
      tx_pre_d = 1'b0;
      if (!tx_pre_q) begin
        tx_shift_d = alrck_lvl ? adc_left : adc_right;
        req_d[alrck_lvl ? CH_LEFT : CH_RIGHT] = 1'b1;
      end
    end else if ((tx_cnt_q == FULL) && !tx_pre_q) begin
      tx_shift_d = alrck_lvl ? adc_right : adc_left;
      req_d[alrck_lvl ? CH_RIGHT : CH_LEFT] = 1'b1;
      tx_pre_d   = 1'b1;
    end
    if (bclk_rise && (tx_cnt_d < FULL)) begin
      if ((tx_cnt_d + CNT_ONE) < FULL) begin
        tx_shift_d = {tx_shift_d[WIDTH-2:0], 1'b0};
      end
      tx_cnt_d = tx_cnt_d + CNT_ONE;
    end
  end

  // Register capture state
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_pre_q   <= 1'b0;
      req_q      <= 2'b00;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_pre_q   <= tx_pre_d;
      req_q      <= req_d;
    end
  end

  assign AUD_ADCDAT = tx_shift_q[WIDTH-1];
  assign dac_sample = sample_q;
  assign dac_valid  = valid_q;
  assign adc_req    = req_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_i2s_codec_target.sv
// tb/tb_i2s_codec_target.sv - scoreboard bench for the codec-side audio target
module tb_i2s_codec_target;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        bclk, lrck, dat;
  logic [15:0] adc_left, adc_right;

  logic        adcdat0, adcdat2;
  logic [15:0] sample0, sample2;
  logic [1:0]  valid0, valid2, req0, req2, ferr0, ferr2;

  i2s_codec_target #(.WIDTH(16), .SYNC_STAGES(0)) dut0 (
    .clk(clk), .reset(reset), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat),
    .AUD_ADCLRCK(lrck), .AUD_ADCDAT(adcdat0), .dac_sample(sample0), .dac_valid(valid0),
    .adc_left(adc_left), .adc_right(adc_right), .adc_req(req0), .frame_err(ferr0));

  i2s_codec_target #(.WIDTH(16), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat),
    .AUD_ADCLRCK(lrck), .AUD_ADCDAT(adcdat2), .dac_sample(sample2), .dac_valid(valid2),
    .adc_left(adc_left), .adc_right(adc_right), .adc_req(req2), .frame_err(ferr2));

  logic        sel;
  logic        m_adcdat;
  logic [15:0] m_sample;
  logic [1:0]  m_valid, m_req, m_ferr;
  assign m_adcdat = sel ? adcdat2 : adcdat0;
  assign m_sample = sel ? sample2 : sample0;
  assign m_valid  = sel ? valid2  : valid0;
  assign m_req    = sel ? req2    : req0;
  assign m_ferr   = sel ? ferr2   : ferr0;

  typedef struct {
    logic        is_err;
    logic        ch;
    logic [15:0] word;
    int          rise_cyc;
    int          lat;
  } dac_ev_t;

  dac_ev_t dac_q[$];
  int      req_q[$];
  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;

  int  half, off, lat_exp;
  bit  m_armed, m_pre;
  int  m_cnt, m_txcnt;
  logic prev_lrck;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  dac_ev_t ev;
  int      rexp;

  // Monitor: pop the expected event whenever the selected DUT pulses an output
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid != 2'b00) begin
        if (dac_q.size() == 0) begin
          chk("dac_valid_unexpected", {30'd0, m_valid}, 32'd0);
        end else begin
          ev = dac_q.pop_front();
          chk("dac_valid_bits", {30'd0, m_valid}, ev.is_err ? 32'd0 : (ev.ch ? 32'd2 : 32'd1));
          chk("dac_sample", {16'd0, m_sample}, {16'd0, ev.word});
          chk("dac_latency", cyc - ev.rise_cyc, ev.lat);
        end
      end
      if (m_ferr != 2'b00) begin
        if (dac_q.size() == 0) begin
          chk("frame_err_unexpected", {30'd0, m_ferr}, 32'd0);
        end else begin
          ev = dac_q.pop_front();
          chk("frame_err_bits", {30'd0, m_ferr}, !ev.is_err ? 32'd0 : (ev.ch ? 32'd2 : 32'd1));
        end
      end
      if (m_req != 2'b00) begin
        if (req_q.size() == 0) begin
          chk("adc_req_unexpected", {30'd0, m_req}, 32'd0);
        end else begin
          rexp = req_q.pop_front();
          chk("adc_req_bits", {30'd0, m_req}, (rexp != 0) ? 32'd2 : 32'd1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #(off);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
    m_armed = 1'b0;
    m_cnt   = 0;
    m_pre   = 1'b0;
    m_txcnt = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_dac_sample"}, {16'd0, m_sample}, 32'd0);
    chk({tag, "_dac_valid"},  {30'd0, m_valid}, 32'd0);
    chk({tag, "_adc_req"},    {30'd0, m_req}, 32'd0);
    chk({tag, "_frame_err"},  {30'd0, m_ferr}, 32'd0);
    chk({tag, "_adcdat"},     {31'd0, m_adcdat}, 32'd0);
  endtask

  // One frame slot as a master would drive it; frame edge and MSB go out with the BCLK fall
  task automatic slot(input logic lr, input logic [15:0] word, input int rises,
                      input int rst_after, input bit chk_adc, input bit chk_next_msb);
    logic [15:0] adc_got;
    logic [15:0] adc_exp;
    logic        nb;
    adc_got = 16'd0;
    adc_exp = lr ? adc_left : adc_right;
    if (m_armed && m_cnt < 16) dac_q.push_back('{1'b1, prev_lrck, 16'd0, 0, 0});
    m_armed = 1'b1;
    m_cnt   = 0;
    if (!m_pre) req_q.push_back(lr ? 1 : 0);
    m_pre   = 1'b0;
    m_txcnt = 0;
    lrck = lr;
    dat  = word[15];
    prev_lrck = lr;
    for (int i = 0; i < rises; i++) begin
      tick(half);
      if (i < 16) adc_got[15-i] = m_adcdat;
      if (i == 16 && chk_next_msb) chk("adcdat_next_msb", {31'd0, m_adcdat}, {31'd0, lr ? adc_right[15] : adc_left[15]});
      bclk = 1'b1;
      if (m_armed && m_cnt < 16) begin
        m_cnt++;
        if (m_cnt == 16) dac_q.push_back('{1'b0, lr, word, cyc, lat_exp});
      end
      if (m_txcnt < 16) begin
        m_txcnt++;
        if (m_txcnt == 16) begin
          req_q.push_back(lr ? 0 : 1);
          m_pre = 1'b1;
        end
      end
      tick(half);
      if (i + 1 < 16) nb = word[14-i];
      else nb = 1'b1;
      bclk = 1'b0;
      dat  = nb;
      if (rst_after == i + 1) begin
        do_reset(1);
        check_zero_outputs("midslot_reset");
      end
    end
    if (chk_adc) chk(lr ? "adc_left_word" : "adc_right_word", {16'd0, adc_got}, {16'd0, adc_exp});
  endtask

  initial begin
    reset = 1'b1; bclk = 1'b0; lrck = 1'b0; dat = 1'b0; sel = 1'b0;
    adc_left = 16'h8001; adc_right = 16'h7FFE;
    off = 1; half = 2; lat_exp = 2; prev_lrck = 1'b0;
    @(posedge clk); #(off);
    do_reset(4);
    check_zero_outputs("reset");
    tick(2);

    // Clock-derived timing, no synchronizer stages
    slot(1'b1, 16'hA5C3, 16, 0, 1'b1, 1'b0);
    slot(1'b0, 16'h0F0F, 16, 0, 1'b1, 1'b0);
    // Short left slot raises frame_err[1]; the right slot still delivers
    slot(1'b1, 16'hFFFF, 9, 0, 1'b0, 1'b0);
    slot(1'b0, 16'h3C96, 16, 0, 1'b1, 1'b0);
    // Over-long slots: trailing bits ignored, next MSB after bit 16
    slot(1'b1, 16'h1234, 24, 0, 1'b1, 1'b1);
    slot(1'b0, 16'hBEEF, 24, 0, 1'b1, 1'b1);
    // Reset after 5 bits of a left slot, then clean recovery
    slot(1'b1, 16'hFFFF, 16, 5, 1'b0, 1'b0);
    slot(1'b0, 16'h5A5A, 16, 0, 1'b1, 1'b0);
    slot(1'b1, 16'hC001, 16, 0, 1'b1, 1'b0);
    tick(12);
    chk("phase1_dac_queue_drained", dac_q.size(), 0);
    chk("phase1_req_queue_drained", req_q.size(), 0);

    // Two synchronizer stages, BCLK period 8 clk, pins off the clk edge
    off = 3; half = 4; lat_exp = 4;
    lrck = 1'b0; bclk = 1'b0; dat = 1'b0;
    do_reset(6);
    sel = 1'b1;
    prev_lrck = 1'b0;
    tick(3);
    slot(1'b1, 16'hA5C3, 16, 0, 1'b1, 1'b0);
    slot(1'b0, 16'h0F0F, 16, 0, 1'b1, 1'b0);
    tick(20);
    chk("phase2_dac_queue_drained", dac_q.size(), 0);
    chk("phase2_req_queue_drained", req_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
